// File: rtl/mem_request_queue.sv
// rtl/mem_request_queue.sv - request FIFO plus single-outstanding issue FSM for one main-memory port
// Optional WAIT-state watchdog: define REQ_TIMEOUT_EN.
module mem_request_queue #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int MSG_BITS       = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [MSG_BITS-1:0] NO_REQ     = MSG_BITS'(0),
  parameter logic [MSG_BITS-1:0] WB_REQ     = MSG_BITS'(1),
  parameter logic [MSG_BITS-1:0] R_REQ      = MSG_BITS'(2),
  parameter logic [MSG_BITS-1:0] MEM_NO_MSG = MSG_BITS'(0),
  parameter logic [MSG_BITS-1:0] MEM_READY  = MSG_BITS'(1),
  parameter logic [MSG_BITS-1:0] MEM_SENT   = MSG_BITS'(2)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDRESS_WIDTH-1:0]      req_address,
  input  logic [DATA_WIDTH-1:0]         req_data,
  output logic                          resp_valid,
  output logic                          resp_write,
  output logic [ADDRESS_WIDTH-1:0]      resp_address,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [MSG_BITS-1:0]           msg_out,
  output logic [ADDRESS_WIDTH-1:0]      address_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  input  logic [MSG_BITS-1:0]           msg_in,
  input  logic [ADDRESS_WIDTH-1:0]      address_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t state, state_next;

  logic                     fifo_write [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data  [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     push, pop, full, empty, match;
  logic                     head_write;
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0]    head_data;

  logic [MSG_BITS-1:0]      msg_next;
  logic [ADDRESS_WIDTH-1:0] address_next, resp_address_next;
  logic [DATA_WIDTH-1:0]    data_next, resp_data_next;
  logic                     resp_valid_next, resp_write_next;

  // The memory echoes the address back, but requests are strictly one at a time.
  logic unused_address_in;
  assign unused_address_in = ^address_in;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign fifo_count = count;
  assign head_write = fifo_write[rd_ptr];
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign match      = (state == WAIT) &&
                      (head_write ? (msg_in == MEM_READY) : (msg_in == MEM_SENT));

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_write[wr_ptr] <= req_write;
      fifo_addr[wr_ptr]  <= req_address;
      fifo_data[wr_ptr]  <= req_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef REQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wait_count, wait_count_next;
  logic          timeout_next;

  // Zero outside WAIT, so the count restarts on every WAIT entry.
  assign wait_count_next = (state == WAIT) ? wait_count + 1'b1 : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_count  <= wait_count_next;
      timeout_err <= timeout_next;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_no_msg;
  assign unused_no_msg = (MEM_NO_MSG == msg_in);
  assign timeout_err   = 1'b0;
`endif

  always_comb begin
    state_next        = state;
    msg_next          = msg_out;
    address_next      = address_out;
    data_next         = data_out;
    resp_valid_next   = 1'b0;
    resp_write_next   = resp_write;
    resp_address_next = resp_address;
    resp_data_next    = resp_data;
    pop               = 1'b0;
`ifdef REQ_TIMEOUT_EN
    timeout_next      = timeout_err;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          msg_next     = head_write ? WB_REQ : R_REQ;
          address_next = head_addr;
          data_next    = head_data;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        if (match) begin
          msg_next          = NO_REQ;
          pop               = 1'b1;
          resp_valid_next   = 1'b1;
          resp_write_next   = head_write;
          resp_address_next = head_addr;
          resp_data_next    = head_write ? '0 : data_in;
          state_next        = GAP;
        end
`ifdef REQ_TIMEOUT_EN
        else if (wait_count == TW'(TIMEOUT_CYCLES - 1)) begin
          msg_next     = NO_REQ;
          pop          = 1'b1;
          timeout_next = 1'b1;
          state_next   = GAP;
        end
`endif
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      msg_out      <= NO_REQ;
      address_out  <= '0;
      data_out     <= '0;
      resp_valid   <= 1'b0;
      resp_write   <= 1'b0;
      resp_address <= '0;
      resp_data    <= '0;
    end else begin
      state        <= state_next;
      msg_out      <= msg_next;
      address_out  <= address_next;
      data_out     <= data_next;
      resp_valid   <= resp_valid_next;
      resp_write   <= resp_write_next;
      resp_address <= resp_address_next;
      resp_data    <= resp_data_next;
    end
  end

endmodule

// File: tb/tb_mem_request_queue.sv
// tb/tb_mem_request_queue.sv - directed table-driven bench for mem_request_queue
// Timeout sequence is compiled in only when REQ_TIMEOUT_EN is defined.
module tb_mem_request_queue;

  localparam int DW = 32, AW = 32, MB = 3, DEPTH = 4, TO = 8;
  localparam logic [2:0] NR = 3'd0, WB = 3'd1, RR = 3'd2, MR = 3'd1, MS = 3'd2;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address, resp_address, address_out, address_in;
  logic [DW-1:0] req_data, resp_data, data_out, data_in;
  logic          resp_valid, resp_write, timeout_err;
  logic [MB-1:0] msg_out, msg_in;
  logic [2:0]    fifo_count;

  int checks = 0;
  int failures = 0;

  mem_request_queue #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_write(resp_write),
    .resp_address(resp_address), .resp_data(resp_data),
    .msg_out(msg_out), .address_out(address_out), .data_out(data_out),
    .msg_in(msg_in), .address_in(address_in), .data_in(data_in),
    .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rv;
    logic        rw;
    logic [31:0] ra;
    logic [31:0] rd;
    logic [2:0]  mi;
    logic [31:0] di;
    logic [2:0]  e_msg;
    logic [31:0] e_addr;
    logic [31:0] e_dout;
    logic        e_rv;
    logic        e_rw;
    logic [31:0] e_raddr;
    logic [31:0] e_rdata;
    logic [2:0]  e_cnt;
    logic        e_ready;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_issue(input logic [2:0] m, input string name);
    int n = 0;
    while (msg_out !== m && n < 20) begin
      tick();
      n++;
    end
    chk({name, " issue msg_out"}, 32'(msg_out), 32'(m));
  endtask

  task automatic complete_read(input logic [31:0] addr, input logic [31:0] data, input string name);
    msg_in  = MS;
    data_in = data;
    tick();
    chk({name, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({name, " resp_address"}, resp_address, addr);
    chk({name, " resp_data"}, resp_data, data);
    chk({name, " resp_write"}, 32'(resp_write), 32'd0);
    msg_in  = NR;
    data_in = '0;
    tick();
    chk({name, " resp pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
    msg_in = NR; address_in = '0; data_in = '0;

    // read 0x100, write/readback 0x200, stray MEM_READY on read 0x300
    vecs[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,        NR, 32'h0,        NR, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'd1, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   32'h0,        NR, 32'h0,        RR, 32'h100, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'd1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   32'h0,        NR, 32'h0,        RR, 32'h100, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        3'd1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,        MS, 32'hDEADBEEF, NR, 32'h100, 32'h0,        1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 3'd0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   32'h0,        NR, 32'h0,        NR, 32'h100, 32'h0,        1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 3'd0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h200, 32'h12345678, NR, 32'h0,        NR, 32'h100, 32'h0,        1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 3'd1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h200, 32'h0,        NR, 32'h0,        WB, 32'h200, 32'h12345678, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 3'd2, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   32'h0,        MR, 32'h0,        NR, 32'h200, 32'h12345678, 1'b1, 1'b1, 32'h200, 32'h0,        3'd1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,   32'h0,        NR, 32'h0,        NR, 32'h200, 32'h12345678, 1'b0, 1'b1, 32'h200, 32'h0,        3'd1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,        NR, 32'h0,        RR, 32'h200, 32'h0,        1'b0, 1'b1, 32'h200, 32'h0,        3'd1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   32'h0,        MS, 32'h12345678, NR, 32'h200, 32'h0,        1'b1, 1'b0, 32'h200, 32'h12345678, 3'd0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   32'h0,        NR, 32'h0,        NR, 32'h200, 32'h0,        1'b0, 1'b0, 32'h200, 32'h12345678, 3'd0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h300, 32'h0,        NR, 32'h0,        NR, 32'h200, 32'h0,        1'b0, 1'b0, 32'h200, 32'h12345678, 3'd1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   32'h0,        NR, 32'h0,        RR, 32'h300, 32'h0,        1'b0, 1'b0, 32'h200, 32'h12345678, 3'd1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h0,   32'h0,        MR, 32'h0,        RR, 32'h300, 32'h0,        1'b0, 1'b0, 32'h200, 32'h12345678, 3'd1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   32'h0,        MS, 32'hCAFEF00D, NR, 32'h300, 32'h0,        1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 3'd0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   32'h0,        NR, 32'h0,        NR, 32'h300, 32'h0,        1'b0, 1'b0, 32'h300, 32'hCAFEF00D, 3'd0, 1'b1};

    tick();
    tick();
    chk("reset msg_out", 32'(msg_out), 32'(NR));
    chk("reset address_out", address_out, 32'h0);
    chk("reset data_out", data_out, 32'h0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_address", resp_address, 32'h0);
    chk("reset resp_data", resp_data, 32'h0);
    chk("reset fifo_count", 32'(fifo_count), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      req_valid   = vecs[i].rv;
      req_write   = vecs[i].rw;
      req_address = vecs[i].ra;
      req_data    = vecs[i].rd;
      msg_in      = vecs[i].mi;
      data_in     = vecs[i].di;
      tick();
      chk($sformatf("v%0d msg_out", i), 32'(msg_out), 32'(vecs[i].e_msg));
      chk($sformatf("v%0d address_out", i), address_out, vecs[i].e_addr);
      chk($sformatf("v%0d data_out", i), data_out, vecs[i].e_dout);
      chk($sformatf("v%0d resp_valid", i), 32'(resp_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d resp_write", i), 32'(resp_write), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d resp_address", i), resp_address, vecs[i].e_raddr);
      chk($sformatf("v%0d resp_data", i), resp_data, vecs[i].e_rdata);
      chk($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
    end
    req_valid = 1'b0; msg_in = NR; data_in = '0;

    // fill the FIFO with the memory stalled; a push at full with a same-cycle pop is refused
    for (int i = 0; i < 4; i++) begin
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_address = 32'h400 + 32'(i * 16);
      req_data    = '0;
      tick();
    end
    chk("full fifo_count", 32'(fifo_count), 32'd4);
    chk("full req_ready", 32'(req_ready), 32'd0);
    req_address = 32'h440;
    tick();
    chk("full refused fifo_count", 32'(fifo_count), 32'd4);
    chk("full head held", address_out, 32'h400);
    msg_in  = MS;
    data_in = 32'hA0A0_0400;
    tick();
    chk("full pop no bypass fifo_count", 32'(fifo_count), 32'd3);
    chk("full first resp_valid", 32'(resp_valid), 32'd1);
    chk("full first resp_address", resp_address, 32'h400);
    chk("full first resp_data", resp_data, 32'hA0A0_0400);
    msg_in  = NR;
    data_in = '0;
    tick();
    chk("fifth accepted fifo_count", 32'(fifo_count), 32'd4);
    req_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      wait_issue(RR, $sformatf("order%0d", i));
      chk($sformatf("order%0d address_out", i), address_out, 32'h400 + 32'(i * 16));
      complete_read(32'h400 + 32'(i * 16), 32'hA0A0_0400 + 32'(i * 16), $sformatf("order%0d", i));
    end
    chk("drained fifo_count", 32'(fifo_count), 32'd0);

    // asynchronous reset mid-WAIT drops everything; late MEM_SENT is ignored
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h500;
    tick();
    req_address = 32'h510;
    tick();
    req_valid = 1'b0;
    wait_issue(RR, "rst");
    chk("rst pre fifo_count", 32'(fifo_count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("rst async msg_out", 32'(msg_out), 32'(NR));
    chk("rst async fifo_count", 32'(fifo_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    msg_in  = MS;
    data_in = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst late%0d resp_valid", i), 32'(resp_valid), 32'd0);
      chk($sformatf("rst late%0d msg_out", i), 32'(msg_out), 32'(NR));
    end
    msg_in  = NR;
    data_in = '0;

`ifdef REQ_TIMEOUT_EN
    begin
      int n;
      bit seen_resp;
      req_valid = 1'b1; req_write = 1'b0; req_address = 32'h600;
      tick();
      req_address = 32'h610;
      tick();
      req_valid = 1'b0;
      wait_issue(RR, "to");
      chk("to pre timeout_err", 32'(timeout_err), 32'd0);
      n = 1;
      seen_resp = 1'b0;
      while (msg_out === RR && address_out === 32'h600 && n < 50) begin
        tick();
        if (resp_valid) seen_resp = 1'b1;
        if (msg_out === RR && address_out === 32'h600) n++;
      end
      chk("to wait cycles", 32'(n), 32'(TO));
      chk("to timeout_err", 32'(timeout_err), 32'd1);
      chk("to no resp_valid", 32'(seen_resp), 32'd0);
      wait_issue(RR, "to next");
      chk("to next address_out", address_out, 32'h610);
      complete_read(32'h610, 32'h6161_6161, "to next");
      chk("to sticky timeout_err", 32'(timeout_err), 32'd1);
    end
`else
    chk("timeout_err tied low", 32'(timeout_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
